prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with optional round-robin fairness.
- Captures a request vector and returns the encoded winning index over a valid/ready output handshake.
- The index is held stable under backpressure.
- Generalises the team's fixed 8x3 encoder. Used as the arbitration front-end for multi-source request buses.

Parameters:
- N, default 8: number of request lines, N >= 2.
- W, default 3: index width. Must equal ceil(log2(N)). The design checks this at elaboration and stops with a fatal error if it does not.

Ports:
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
- req  input  N: request vector. Bit i set means source i is requesting.
- rr_en  input  1: 0 = fixed priority, 1 = round-robin. Sampled only at capture.
- out_ready  input  1: consumer accepts the current index this cycle.
- out_valid  output  1: idx and multi hold a valid result.
- idx  output  W: encoded winning request index.
- multi  output  1: more than one req bit was set at capture.

Behaviour:
- Reset is asynchronous: the instant rst_n falls, out_valid=0, idx=0, multi=0, last=0 and state=IDLE, regardless of clock. Release is synchronous to the next clk edge.
- last is an internal W-bit register holding the index of the most recently accepted grant.
- State IDLE (out_valid=0):
  - If |req=1 on a clk edge: register idx=winner(req), multi=(popcount(req)>1), and go to HOLD.
  - Otherwise stay in IDLE; idx and multi keep their old values.
  - Latency from req to out_valid is 1 cycle.
- State HOLD (out_valid=1):
  - idx and multi are frozen. Changes on req and rr_en are ignored.
  - If out_ready=1 on a clk edge, that is an accept: last=idx. Then, in the same edge:
    - If |req=1, capture a new winner and stay in HOLD (back-to-back, no bubble).
    - Otherwise go to IDLE.
  - If out_ready=0, stay in HOLD with no change.
- Winner, fixed mode (rr_en=0): the highest-index set bit wins.
- Winner, round-robin mode (rr_en=1):
  - Search downward starting at (last-1) mod N and wrapping, ending at last.
  - The first set bit found wins, so the previously accepted index has the lowest priority.
  - For a back-to-back capture, the search uses the updated last, i.e. the index just accepted.
- last updates on every accept in both modes, but only influences the winner when rr_en=1. With last=0 after reset, round-robin order equals fixed order.
- req=0 never produces out_valid.
- A single set bit wins in both modes.
- Non-power-of-two N: index values >= N are never produced. The wrap in the round-robin search is modulo N, not 2^W.
- out_valid does not drop without an accept, except on reset.
- No combinational path from req or out_ready to any output. All outputs are registered.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=8'hFF -> out_valid=0, idx=0 and multi=0 immediately, with no clk edge needed.
- One-hot sweep: fixed mode, out_ready=1, req=8'b00000001 through 8'b10000000 with each vector held for one edge -> idx=0..7 one cycle later, multi=0, out_valid continuous.
- Fixed priority: rr_en=0, req=8'b10101010 held, out_ready=1 -> idx=7 every cycle, multi=1.
- Round-robin: rr_en=1, req=8'b10101010 held, out_ready=1 from reset -> idx sequence 7,5,3,1,7,5 on consecutive cycles, with no out_valid gaps.
- Backpressure: capture req=8'b10000000, hold out_ready=0 for 3 cycles while req changes to 8'b00000100 -> idx stays 7 and out_valid stays 1. On the accept edge idx becomes 2.
- Reset mid-HOLD: in round-robin mode after accepting idx=5, pull rst_n low while out_valid=1 -> out_valid=0 at once. After release with req=8'b10101010, the first grant is idx=7 because last was reset to 0.

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// rtl/prio_encoder_rr_if.sv - request/grant bundle for the round-robin priority encoder
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] req;
  logic         rr_en;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] idx;
  logic         multi;

  modport master (
    output req, rr_en, out_ready,
    input  out_valid, idx, multi
  );

  modport slave (
    input  req, rr_en, out_ready,
    output out_valid, idx, multi
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered N-to-log2(N) priority encoder with optional round-robin
// The grant is held in HOLD until accepted; last remembers the previous accepted index.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prio_encoder_rr_if.slave     bus
);

  generate
    if (N < 2 || W != $clog2(N)) begin : g_bad_param
      $fatal(1, "prio_encoder_rr: W must equal ceil(log2(N)) and N must be >= 2");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t       state_q;
  logic         out_valid_q;
  logic [W-1:0] idx_q;
  logic         multi_q;
  logic [W-1:0] last_q;

  logic [W-1:0] base;
  logic [W-1:0] win_fix;
  logic [W-1:0] win_rr;
  logic [W-1:0] idx_d;
  logic         multi_d;
  logic         found;
  int           j;

  // On an accept edge the search must start from the index being accepted now,
  // not from the stale last_q, so back-to-back captures rotate correctly.
  always_comb begin
    base    = (state_q == HOLD) ? idx_q : last_q;
    win_fix = '0;
    win_rr  = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) win_fix = W'(i);
    end
    for (int k = 1; k <= N; k++) begin
      j = (int'(base) >= k) ? int'(base) - k : int'(base) + N - k;
      if (!found && bus.req[j]) begin
        found  = 1'b1;
        win_rr = W'(j);
      end
    end
    idx_d   = bus.rr_en ? win_rr : win_fix;
    multi_d = |(bus.req & (bus.req - N'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      multi_q     <= 1'b0;
      last_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            idx_q       <= idx_d;
            multi_q     <= multi_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            last_q <= idx_q;
            if (|bus.req) begin
              idx_q   <= idx_d;
              multi_q <= multi_d;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.multi     = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - directed vector bench for prio_encoder_rr
module tb_prio_encoder_rr;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  prio_encoder_rr_if #(.N(8), .W(3)) bus ();

  prio_encoder_rr #(.N(8), .W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rr;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic       m;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int vn, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, vn, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int vn, input logic v, input logic [2:0] ix, input logic m);
    chk({name, ".out_valid"}, vn, 32'(bus.out_valid), 32'(v));
    chk({name, ".idx"},       vn, 32'(bus.idx),       32'(ix));
    chk({name, ".multi"},     vn, 32'(bus.multi),     32'(m));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    bus.rr_en = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input logic [7:0] r, input logic rr, input logic rdy);
    bus.req = r;
    bus.rr_en = rr;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.rr_en = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset from a loaded HOLD state, no clock edge in between
    apply(8'hFF, 1'b0, 1'b0);
    chk_out("pre_reset", 0, 1'b1, 3'd7, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    bus.req = '0;
    rst_n = 1'b1;

    // one-hot sweep, fixed mode
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{(i == 0), 8'(1 << i), 1'b0, 1'b1, 1'b1, 3'(i), 1'b0});
    end
    // fixed priority
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1});
    // round-robin from reset: 7,5,3,1,7,5
    tbl.push_back('{1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1});
    tbl.push_back('{1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1});
    tbl.push_back('{1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1});
    tbl.push_back('{1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1});
    tbl.push_back('{1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1});
    tbl.push_back('{1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1});
    // backpressure: capture 7, hold three cycles while req moves to bit 2
    tbl.push_back('{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0});
    tbl.push_back('{1'b0, 8'h0C, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0});
    // accept with no request drops to IDLE; idx/multi keep their values
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0});
    // round-robin after last=2: search 1,0,7.. -> 0, then 6
    tbl.push_back('{1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1});
    tbl.push_back('{1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].req, tbl[i].rr, tbl[i].rdy);
      chk_out("table", i + 1, tbl[i].v, tbl[i].idx, tbl[i].m);
    end

    // Reset while holding a round-robin grant clears last as well
    do_reset();
    apply(8'hAA, 1'b1, 1'b1);
    chk_out("mid_hold.g0", 0, 1'b1, 3'd7, 1'b1);
    apply(8'hAA, 1'b1, 1'b1);
    chk_out("mid_hold.g1", 0, 1'b1, 3'd5, 1'b1);
    apply(8'hAA, 1'b1, 1'b1);
    chk_out("mid_hold.g2", 0, 1'b1, 3'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_hold.rst", 0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hAA, 1'b1, 1'b0);
    chk_out("mid_hold.after", 0, 1'b1, 3'd7, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
